// File: rtl/mem_branch_resolver.sv
// MEM-stage branch resolver: flag-based branch decision, forwarding mux, MEM/WB register and post-branch squash.
// Optional statistics counters are built only when MEM_BR_STATS_EN is defined.
module mem_branch_resolver #(
    parameter  int DATA_W      = 16,
    parameter  int NUM_FWD     = 2,
    parameter  int FLUSH_DEPTH = 2,
    parameter  int CNT_W       = 16,
    localparam int SEL_W       = $clog2(NUM_FWD + 1),
    localparam int FC_W        = (FLUSH_DEPTH > 0) ? $clog2(FLUSH_DEPTH + 1) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      hlt,
    input  logic                      in_valid,
    input  logic                      in_is_branch,
    input  logic [2:0]                in_branch_op,
    input  logic                      in_pc_src,
    input  logic [2:0]                in_flags,
    input  logic                      in_flags_we,
    input  logic [DATA_W-1:0]         in_mem_data,
    input  logic [NUM_FWD*DATA_W-1:0] fwd_data,
    input  logic [SEL_W-1:0]          fwd_sel,
    output logic                      cntrl_branch,
    output logic                      flush_active,
    output logic [2:0]                flags_q,
    output logic                      wb_valid,
    output logic [DATA_W-1:0]         wb_data,
    output logic [CNT_W-1:0]          stat_branches,
    output logic [CNT_W-1:0]          stat_taken
);

    localparam logic [2:0] OP_NEQ    = 3'b000;
    localparam logic [2:0] OP_EQ     = 3'b001;
    localparam logic [2:0] OP_GT     = 3'b010;
    localparam logic [2:0] OP_LT     = 3'b011;
    localparam logic [2:0] OP_GTE    = 3'b100;
    localparam logic [2:0] OP_LTE    = 3'b101;
    localparam logic [2:0] OP_OVFL   = 3'b110;
    localparam logic [2:0] OP_UNCOND = 3'b111;

    logic [2:0]        r_flags;
    logic [FC_W-1:0]   r_fcnt;
    logic              r_wb_valid;
    logic [DATA_W-1:0] r_wb_data;

    logic              w_live;
    logic              w_cond;
    logic              w_branch;
    logic              w_z;
    logic              w_v;
    logic              w_n;
    logic [DATA_W-1:0] w_sel_data;

    assign w_live = in_valid & (r_fcnt == '0);
    assign w_z    = r_flags[2];
    assign w_v    = r_flags[1];
    assign w_n    = r_flags[0];

    // Conditions read only the stored flags, never this instruction's in_flags.
    always_comb begin
        w_cond = 1'b0;
        case (in_branch_op)
            OP_NEQ:    w_cond = ~w_z;
            OP_EQ:     w_cond = w_z;
            OP_GT:     w_cond = ~w_z & ~w_n;
            OP_LT:     w_cond = w_n;
            OP_GTE:    w_cond = ~w_n;
            OP_LTE:    w_cond = w_n | w_z;
            OP_OVFL:   w_cond = w_v;
            OP_UNCOND: w_cond = 1'b1;
            default:   w_cond = 1'b0;
        endcase
    end

    always_comb begin
        w_branch = 1'b0;
        if (w_live && !hlt)
            w_branch = in_is_branch ? w_cond : in_pc_src;
    end

    // Out-of-range selects fall back to the memory read data.
    always_comb begin
        w_sel_data = in_mem_data;
        for (int k = 1; k <= NUM_FWD; k++) begin
            if (fwd_sel == SEL_W'(k))
                w_sel_data = fwd_data[k*DATA_W-1 -: DATA_W];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flags <= '0;
        end else if (!hlt && w_live && in_flags_we) begin
            r_flags <= in_flags;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wb_valid <= 1'b0;
            r_wb_data  <= '0;
        end else if (!hlt) begin
            r_wb_valid <= w_live;
            if (w_live)
                r_wb_data <= w_sel_data;
        end
    end

    // With FLUSH_DEPTH=0 the load value is 0, so the counter never leaves zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fcnt <= '0;
        end else if (!hlt) begin
            if (w_branch)
                r_fcnt <= FC_W'(FLUSH_DEPTH);
            else if (r_fcnt != '0)
                r_fcnt <= r_fcnt - FC_W'(1);
        end
    end

`ifdef MEM_BR_STATS_EN
    logic [CNT_W-1:0] r_stat_br;
    logic [CNT_W-1:0] r_stat_tk;
    logic             w_br_seen;

    assign w_br_seen = w_live & in_is_branch & ~hlt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_br <= '0;
            r_stat_tk <= '0;
        end else if (w_br_seen) begin
            if (r_stat_br != '1)
                r_stat_br <= r_stat_br + CNT_W'(1);
            if (w_branch && r_stat_tk != '1)
                r_stat_tk <= r_stat_tk + CNT_W'(1);
        end
    end

    assign stat_branches = r_stat_br;
    assign stat_taken    = r_stat_tk;
`else
    assign stat_branches = '0;
    assign stat_taken    = '0;
`endif

    assign cntrl_branch = w_branch;
    assign flush_active = (r_fcnt != '0);
    assign flags_q      = r_flags;
    assign wb_valid     = r_wb_valid;
    assign wb_data      = r_wb_data;

endmodule

// File: tb/tb_mem_branch_resolver.sv
// Directed bench for mem_branch_resolver: table-driven branch/forwarding vectors plus squash, halt, reset and stats sequences.
module tb_mem_branch_resolver;

    localparam int DATA_W  = 16;
    localparam int NUM_FWD = 2;
    localparam int FD      = 2;
    localparam int CNT_W   = 4;
    localparam int SEL_W   = $clog2(NUM_FWD + 1);

    logic                      clk = 1'b0;
    logic                      rst_n = 1'b0;
    logic                      hlt = 1'b0;
    logic                      in_valid = 1'b0;
    logic                      in_is_branch = 1'b0;
    logic [2:0]                in_branch_op = 3'b000;
    logic                      in_pc_src = 1'b0;
    logic [2:0]                in_flags = 3'b000;
    logic                      in_flags_we = 1'b0;
    logic [DATA_W-1:0]         in_mem_data = '0;
    logic [NUM_FWD*DATA_W-1:0] fwd_data = '0;
    logic [SEL_W-1:0]          fwd_sel = '0;
    logic                      cntrl_branch;
    logic                      flush_active;
    logic [2:0]                flags_q;
    logic                      wb_valid;
    logic [DATA_W-1:0]         wb_data;
    logic [CNT_W-1:0]          stat_branches;
    logic [CNT_W-1:0]          stat_taken;

    int total = 0;
    int bad   = 0;

    mem_branch_resolver #(
        .DATA_W(DATA_W), .NUM_FWD(NUM_FWD), .FLUSH_DEPTH(FD), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .hlt(hlt), .in_valid(in_valid),
        .in_is_branch(in_is_branch), .in_branch_op(in_branch_op), .in_pc_src(in_pc_src),
        .in_flags(in_flags), .in_flags_we(in_flags_we), .in_mem_data(in_mem_data),
        .fwd_data(fwd_data), .fwd_sel(fwd_sel), .cntrl_branch(cntrl_branch),
        .flush_active(flush_active), .flags_q(flags_q), .wb_valid(wb_valid),
        .wb_data(wb_data), .stat_branches(stat_branches), .stat_taken(stat_taken)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic alu(input logic [2:0] f, input logic we, input logic [DATA_W-1:0] d);
        in_valid = 1'b1; in_is_branch = 1'b0; in_pc_src = 1'b0;
        in_flags = f; in_flags_we = we; in_mem_data = d; fwd_sel = '0;
    endtask

    task automatic br(input logic [2:0] op, input logic [DATA_W-1:0] d);
        in_valid = 1'b1; in_is_branch = 1'b1; in_branch_op = op; in_pc_src = 1'b0;
        in_flags = 3'b111; in_flags_we = 1'b0; in_mem_data = d; fwd_sel = '0;
    endtask

    task automatic idle();
        in_valid = 1'b0; in_is_branch = 1'b0; in_pc_src = 1'b0; in_flags_we = 1'b0;
    endtask

    typedef struct {
        logic [2:0] flags;
        logic [2:0] op;
        logic       exp;
    } br_vec_t;

    typedef struct {
        logic [SEL_W-1:0]  sel;
        logic [DATA_W-1:0] exp;
    } fwd_vec_t;

    br_vec_t  bv[16];
    fwd_vec_t fv[4];

    initial begin
        // flags are {Z,V,N}
        bv[0]  = '{3'b100, 3'b001, 1'b1};  // Z: EQ
        bv[1]  = '{3'b100, 3'b000, 1'b0};  // Z: NEQ
        bv[2]  = '{3'b100, 3'b100, 1'b1};  // Z: GTE
        bv[3]  = '{3'b100, 3'b011, 1'b0};  // Z: LT
        bv[4]  = '{3'b100, 3'b111, 1'b1};  // Z: UNCOND
        bv[5]  = '{3'b100, 3'b010, 1'b0};  // Z: GT
        bv[6]  = '{3'b100, 3'b101, 1'b1};  // Z: LTE
        bv[7]  = '{3'b000, 3'b010, 1'b1};  // none: GT
        bv[8]  = '{3'b000, 3'b101, 1'b0};  // none: LTE
        bv[9]  = '{3'b000, 3'b000, 1'b1};  // none: NEQ
        bv[10] = '{3'b000, 3'b110, 1'b0};  // none: OVFL
        bv[11] = '{3'b010, 3'b110, 1'b1};  // V: OVFL
        bv[12] = '{3'b001, 3'b011, 1'b1};  // N: LT
        bv[13] = '{3'b001, 3'b100, 1'b0};  // N: GTE
        bv[14] = '{3'b001, 3'b010, 1'b0};  // N: GT
        bv[15] = '{3'b101, 3'b101, 1'b1};  // Z,N: LTE
        fv[0]  = '{2'd0, 16'h1111};
        fv[1]  = '{2'd1, 16'hAAAA};
        fv[2]  = '{2'd2, 16'hBBBB};
        fv[3]  = '{2'd3, 16'h1111};

        #2;
        chk("rst_flags", 32'(flags_q), 32'h0);
        chk("rst_flush", 32'(flush_active), 32'h0);
        chk("rst_wbv", 32'(wb_valid), 32'h0);
        chk("rst_wbd", 32'(wb_data), 32'h0);
        chk("rst_statb", 32'(stat_branches), 32'h0);
        chk("rst_statt", 32'(stat_taken), 32'h0);
        #10 rst_n = 1'b1;
        step();

        // Branch conditions: load flags with a live ALU op, then present the branch unclocked.
        for (int i = 0; i < 16; i++) begin
            alu(bv[i].flags, 1'b1, 16'h0);
            step();
            chk($sformatf("flags_ld[%0d]", i), 32'(flags_q), 32'(bv[i].flags));
            br(bv[i].op, 16'h0);
            in_flags = ~bv[i].flags;
            #1;
            chk($sformatf("br[%0d]", i), 32'(cntrl_branch), 32'(bv[i].exp));
            idle();
            #1;
        end

        alu(3'b000, 1'b0, 16'h0);
        in_pc_src = 1'b1;
        #1 chk("jump_live", 32'(cntrl_branch), 32'h1);
        in_valid = 1'b0;
        #1 chk("jump_invalid", 32'(cntrl_branch), 32'h0);
        br(3'b111, 16'h0);
        hlt = 1'b1;
        #1 chk("br_hlt", 32'(cntrl_branch), 32'h0);
        hlt = 1'b0;
        idle();

        // Forwarding select.
        alu(3'b000, 1'b0, 16'h1111);
        fwd_data = {16'hBBBB, 16'hAAAA};
        for (int i = 0; i < 4; i++) begin
            fwd_sel = fv[i].sel;
            step();
            chk($sformatf("fwd_v[%0d]", i), 32'(wb_valid), 32'h1);
            chk($sformatf("fwd_d[%0d]", i), 32'(wb_data), 32'(fv[i].exp));
        end
        fwd_sel = '0;

        // Squash window after a taken branch.
        alu(3'b100, 1'b1, 16'h0);
        step();
        br(3'b111, 16'h0);
        #1 chk("sq_br_taken", 32'(cntrl_branch), 32'h1);
        step();
        chk("sq_br_wbv", 32'(wb_valid), 32'h1);
        chk("sq_flush0", 32'(flush_active), 32'h1);
        alu(3'b001, 1'b1, 16'h0);
        for (int c = 1; c <= 2; c++) begin
            #1 chk($sformatf("sq_cb%0d", c), 32'(cntrl_branch), 32'h0);
            chk($sformatf("sq_flush%0d", c), 32'(flush_active), 32'h1);
            step();
            chk($sformatf("sq_wbv%0d", c), 32'(wb_valid), 32'h0);
            chk($sformatf("sq_flags%0d", c), 32'(flags_q), 32'h4);
        end
        chk("sq_flush3", 32'(flush_active), 32'h0);
        step();
        chk("sq_wbv3", 32'(wb_valid), 32'h1);
        chk("sq_flags3", 32'(flags_q), 32'h1);

        // A squashed branch cannot restart the window.
        br(3'b111, 16'h0);
        step();
        chk("sq2_flush", 32'(flush_active), 32'h1);
        #1 chk("sq2_cb_squashed", 32'(cntrl_branch), 32'h0);
        step();
        step();
        chk("sq2_done", 32'(flush_active), 32'h0);
        chk("sq2_wbv", 32'(wb_valid), 32'h0);
        idle();
        step();

        // Halt freezes the squash counter and the MEM/WB register.
        br(3'b111, 16'h5555);
        step();
        alu(3'b000, 1'b0, 16'h2222);
        hlt = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            chk($sformatf("hlt_flush%0d", c), 32'(flush_active), 32'h1);
            chk($sformatf("hlt_cb%0d", c), 32'(cntrl_branch), 32'h0);
            chk($sformatf("hlt_wbv%0d", c), 32'(wb_valid), 32'h1);
            chk($sformatf("hlt_wbd%0d", c), 32'(wb_data), 32'h5555);
        end
        hlt = 1'b0;
        step();
        chk("hlt_rel_wbv1", 32'(wb_valid), 32'h0);
        chk("hlt_rel_flush1", 32'(flush_active), 32'h1);
        step();
        chk("hlt_rel_wbv2", 32'(wb_valid), 32'h0);
        chk("hlt_rel_flush2", 32'(flush_active), 32'h0);
        step();
        chk("hlt_rel_wbv3", 32'(wb_valid), 32'h1);
        chk("hlt_rel_wbd3", 32'(wb_data), 32'h2222);

        // Asynchronous reset in the middle of a squash.
        alu(3'b011, 1'b1, 16'h0);
        step();
        br(3'b111, 16'h7777);
        step();
        chk("ar_pre_flush", 32'(flush_active), 32'h1);
        idle();
        #2 rst_n = 1'b0;
        #1;
        chk("ar_flush", 32'(flush_active), 32'h0);
        chk("ar_wbv", 32'(wb_valid), 32'h0);
        chk("ar_flags", 32'(flags_q), 32'h0);
        chk("ar_wbd", 32'(wb_data), 32'h0);
        #2 rst_n = 1'b1;
        alu(3'b000, 1'b0, 16'h3333);
        step();
        chk("ar_post_wbv", 32'(wb_valid), 32'h1);
        chk("ar_post_wbd", 32'(wb_data), 32'h3333);

        // Statistics saturation: 20 taken branches spaced past the squash window.
        for (int i = 0; i < 20; i++) begin
            br(3'b111, 16'h0);
            step();
            idle();
            step(); step(); step();
        end
`ifdef MEM_BR_STATS_EN
        chk("stat_branches", 32'(stat_branches), 32'd15);
        chk("stat_taken", 32'(stat_taken), 32'd15);
`else
        chk("stat_branches", 32'(stat_branches), 32'd0);
        chk("stat_taken", 32'(stat_taken), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_branch_resolver.md
Name: mem_branch_resolver

Overview:
Parametrised next-generation memory-stage block for the pipeline.
- Resolves conditional and unconditional branches against a stored Z/V/N flag register.
- Selects MEM-stage write data from the memory read or one of NUM_FWD forwarding sources.
- Registers the result into the MEM/WB boundary.
- Squashes wrong-path instructions for a configurable number of cycles after a taken branch.

Parameters:
DATA_W, 16, width of data paths
NUM_FWD, 2, number of forwarding sources (at least 1)
FLUSH_DEPTH, 2, cycles of wrong-path squash after a taken branch (0 = no squash)
CNT_W, 16, width of statistics counters (used only with the optional feature)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
hlt  in  1  freeze: no state changes while high
in_valid  in  1  instruction present in MEM this cycle
in_is_branch  in  1  instruction is a conditional/unconditional branch
in_branch_op  in  3  000 NEQ, 001 EQ, 010 GT, 011 LT, 100 GTE, 101 LTE, 110 OVFL, 111 UNCOND
in_pc_src  in  1  non-branch redirect request (jump), passed through when in_is_branch=0
in_flags  in  3  {Z,V,N} produced by this instruction
in_flags_we  in  1  this instruction updates the flag register
in_mem_data  in  DATA_W  data-memory read / ALU result
fwd_data  in  NUM_FWD*DATA_W  forwarding sources; slice k-1 is source k
fwd_sel  in  SEL_W=$clog2(NUM_FWD+1)  0 selects in_mem_data; k selects source k
cntrl_branch  out  1  combinational redirect decision
flush_active  out  1  squash counter nonzero
flags_q  out  3  stored {Z,V,N}
wb_valid  out  1  registered: valid result at MEM/WB
wb_data  out  DATA_W  registered write data
stat_branches  out  CNT_W  branches resolved (optional feature)
stat_taken  out  CNT_W  branches taken (optional feature)

Behaviour:
- Reset (rst_n low, asynchronous): flags_q=0, flush counter=0, wb_valid=0, wb_data=0, stats=0.
- Squash condition: live = in_valid & (flush counter == 0).

cntrl_branch (combinational):
- 0 if ~live.
- in_pc_src if ~in_is_branch.
- Otherwise evaluated on flags_q:
  - NEQ: ~Z
  - EQ: Z
  - GT: ~Z & ~N
  - LT: N
  - GTE: ~N
  - LTE: N|Z
  - OVFL: V
  - UNCOND: 1
- Forced to 0 while hlt is high.

Flag register:
- Loads in_flags on the clock edge when live & in_flags_we & ~hlt.
- A branch never reads its own in_flags.

Write-data select:
- sel_data = fwd_sel==0 ? in_mem_data : fwd_data slice (fwd_sel-1).
- fwd_sel > NUM_FWD selects in_mem_data.

MEM/WB register, one-cycle latency, when ~hlt:
- wb_valid <= live
- wb_data <= sel_data when live; holds otherwise.

Flush counter, when ~hlt:
- If cntrl_branch=1: load FLUSH_DEPTH.
- Else if nonzero: decrement.
- Counter width is max(1, $clog2(FLUSH_DEPTH+1)).
- The branching instruction itself is live and writes wb normally.
- Instructions arriving in the next FLUSH_DEPTH non-halted cycles are squashed: no flags, no wb_valid, no cntrl_branch.
- A squashed branch cannot reload the counter.
- FLUSH_DEPTH=0: the counter stays 0 and nothing is ever squashed.

hlt:
- All registers hold, including the counter, which does not count down during hlt.
- Outputs keep their values; cntrl_branch is 0.
- Squash resumes where it left off when hlt drops.

Reset mid-squash clears the counter immediately; the next live instruction is accepted.

Optional Feature:
MEM_BR_STATS_EN
- Defined:
  - stat_branches increments on each live & in_is_branch & ~hlt cycle.
  - stat_taken increments when that branch also has cntrl_branch=1.
  - Both saturate at 2^CNT_W-1 and clear on reset.
- Undefined: both ports are tied to 0 and no counter logic is built.

Test Plan:
1. flags_q={Z=1,V=0,N=0}; EQ branch live -> cntrl_branch=1. NEQ -> 0. GTE -> 1. LT -> 0. UNCOND -> 1.
2. FLUSH_DEPTH=2; taken branch at cycle 0, then valid ALU ops at cycles 1,2,3 with flags_we, in_flags=3'b001 -> cycles 1 and 2 squashed (wb_valid=0, flags_q unchanged); cycle 3 live; flags_q=3'b001 after cycle 3; flush_active high in cycles 1-2.
3. NUM_FWD=2; in_mem_data=16'h1111, fwd_data={16'hBBBB,16'hAAAA}; fwd_sel=0/1/2/3 -> wb_data one cycle later = 1111/AAAA/BBBB/1111.
4. Taken branch, then hlt high 3 cycles, then release -> counter frozen at 2 during hlt; cntrl_branch=0 and wb_* held; 2 squash cycles after release.
5. rst_n pulsed low mid-squash (asynchronous, between edges) -> flush_active, wb_valid, flags_q drop to 0 immediately; first valid instruction after release is live.
6. MEM_BR_STATS_EN, CNT_W=4; 20 taken branches spaced beyond the flush window -> stat_branches=stat_taken=15 (saturated). Without the macro, both read 0.
